// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte streams: round-robin arbitration with
// message locking, then load / start / busy-track / inter-byte gap for each byte.
//
// state     | meaning
// IDLE      | choose owner (while locked only the current owner may proceed)
// ACCEPT    | req_ready pulse to owner, capture byte and last flag
// LAUNCH    | tx_start pulse
// WAIT_BUSY | wait for the transmitter to go busy, bounded by BUSY_TIMEOUT
// WAIT_DONE | wait for the frame to finish shifting
// GAP       | enforced idle time before the next byte
module uart_tx_sched #(
    parameter int  NUM_REQ      = 4,
    parameter int  GAP_CYCLES   = 16,
    parameter int  BUSY_TIMEOUT = 64,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 locked_o,
    output logic                 timeout_err_o
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    localparam state_e POST_BYTE = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_e               state_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [7:0]           tx_data_q;
    logic                 tx_start_q;
    logic [IDW-1:0]       grant_id_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic                 locked_q;
    logic                 timeout_err_q;
    logic [TW-1:0]        busy_cnt_q;
    logic [GW-1:0]        gap_cnt_q;

    logic [IDW-1:0]       arb_idx_d;
    logic                 arb_hit_d;
    logic [IDW-1:0]       cand;
    logic [IDW-1:0]       rr_next_d;

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        arb_hit_d = 1'b0;
        arb_idx_d = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid_i[cand]) begin
                arb_hit_d = 1'b1;
                arb_idx_d = cand;
            end
        end
    end

    assign rr_next_d = IDW'((int'(grant_id_q) + 1) % NUM_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            locked_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (locked_q) begin
                        if (req_valid_i[grant_id_q]) begin
                            req_ready_q <= NUM_REQ'(1) << grant_id_q;
                            state_q     <= S_ACCEPT;
                        end
                    end else if (arb_hit_d) begin
                        grant_id_q  <= arb_idx_d;
                        req_ready_q <= NUM_REQ'(1) << arb_idx_d;
                        state_q     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    tx_data_q <= req_data_i[{grant_id_q, 3'b000} +: 8];
                    if (req_last_i[grant_id_q]) begin
                        locked_q <= 1'b0;
                        rr_ptr_q <= rr_next_d;
                    end else begin
                        locked_q <= 1'b1;
                    end
                    tx_start_q <= 1'b1;
                    state_q    <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    busy_cnt_q <= '0;
                    state_q    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else if (busy_cnt_q == BUSY_LAST) begin
                        // Byte is dropped; lock state is left as the accept set it.
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= POST_BYTE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        gap_cnt_q <= '0;
                        state_q   <= POST_BYTE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign tx_data_o     = tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign grant_id_o    = grant_id_q;
    assign locked_o      = locked_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: per-requester expected byte queues filled by the driver,
// a negedge monitor holding a behavioural arbitration/timing model, plus a GAP_CYCLES=0 instance.
module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int G  = 4;
    localparam int BT = 8;

    typedef logic [8:0] ent_t;   // {last, data}

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [8*NR-1:0] req_data;
    logic [7:0]      tx_data;
    logic            tx_start, tx_busy;
    logic [1:0]      grant_id;
    logic            locked, timeout_err;

    logic [1:0]  req_valid_b, req_last_b, req_ready_b;
    logic [15:0] req_data_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b, tx_busy_b;
    logic [0:0]  grant_id_b;
    logic        locked_b, timeout_err_b;

    uart_tx_sched #(.NUM_REQ(NR), .GAP_CYCLES(G), .BUSY_TIMEOUT(BT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_start_o(tx_start),
        .tx_busy_i(tx_busy), .grant_id_o(grant_id), .locked_o(locked),
        .timeout_err_o(timeout_err)
    );

    uart_tx_sched #(.NUM_REQ(2), .GAP_CYCLES(0), .BUSY_TIMEOUT(BT)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_b), .req_data_i(req_data_b), .req_last_i(req_last_b),
        .req_ready_o(req_ready_b), .tx_data_o(tx_data_b), .tx_start_o(tx_start_b),
        .tx_busy_i(tx_busy_b), .grant_id_o(grant_id_b), .locked_o(locked_b),
        .timeout_err_o(timeout_err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter models: busy rises 2 cycles after tx_start and stays high 20 cycles.
    int tx_t = 0;
    int tb_t = 0;
    bit tx_dead = 1'b0;
    always @(posedge clk) begin
        if (tx_start && !tx_dead) tx_t <= 1;
        else if (tx_t != 0)       tx_t <= (tx_t == 21) ? 0 : tx_t + 1;
        if (tx_start_b)           tb_t <= 1;
        else if (tb_t != 0)       tb_t <= (tb_t == 21) ? 0 : tb_t + 1;
    end
    assign tx_busy   = (tx_t >= 2);
    assign tx_busy_b = (tb_t >= 2);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    ent_t src[NR][$];
    ent_t exp_q[NR][$];
    bit   rand_mode = 1'b0;
    bit   mon_en = 1'b0;

    // Reference model state (owned by the monitor).
    int          ptr_m, owner_m, exp_start, earliest;
    bit          lock_m, free_m, exp_terr;
    ent_t        pend;
    logic [NR-1:0] prev_valid;
    logic [7:0]  tx_log[$];
    int          grant_log[$];

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NR-1:0] elig, exp_oh;
        bit            er;
        int            idx;
        if (!rst_n) begin
            ptr_m = 0; owner_m = 0; lock_m = 1'b0; free_m = 1'b1; earliest = 0;
            exp_start = -1; exp_terr = 1'b0; pend = '0; prev_valid = '0;
            for (int i = 0; i < NR; i++) exp_q[i].delete();
        end else if (mon_en) begin
            elig = lock_m ? (prev_valid & (NR'(1) << owner_m)) : prev_valid;
            er   = free_m && (cyc >= earliest) && (elig != 0);
            if (er || req_ready != 0)
                check(er == (req_ready != 0), "ready_timing", req_ready, er);
            if (req_ready != 0) begin
                idx    = pick(elig, ptr_m);
                exp_oh = (idx >= 0) ? (NR'(1) << idx) : '0;
                check(req_ready == exp_oh, "grant_onehot", req_ready, exp_oh);
                check(idx >= 0 && int'(grant_id) == idx, "grant_id", grant_id, idx);
                if (idx >= 0 && exp_q[idx].size() > 0) begin
                    pend = exp_q[idx].pop_front();
                    grant_log.push_back(idx);
                    owner_m = idx;
                    lock_m  = !pend[8];
                    if (pend[8]) ptr_m = (idx + 1) % NR;
                end else begin
                    check(1'b0, "spurious_accept", req_ready, 0);
                end
                free_m    = 1'b0;
                exp_start = cyc + 1;
            end
            if (tx_start || cyc == exp_start) begin
                check(tx_start && cyc == exp_start, "start_latency", tx_start, 1);
                check(tx_data == pend[7:0], "tx_data", tx_data, pend[7:0]);
                check(locked == !pend[8], "locked", locked, !pend[8]);
                check(timeout_err == exp_terr, "timeout_err", timeout_err, exp_terr);
                tx_log.push_back(tx_data);
                earliest  = tx_dead ? cyc + BT + G + 2 : cyc + 24 + G;
                exp_terr  = exp_terr | tx_dead;
                free_m    = 1'b1;
                exp_start = -1;
            end
            prev_valid = req_valid;
        end
    end

    task automatic step();
        logic [NR-1:0] tk;
        ent_t e;
        @(negedge clk);
        tk = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (tk[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && src[i].size() > 0 && (!rand_mode || $urandom_range(0, 3) == 0)) begin
                e = src[i].pop_front();
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
                req_valid[i]       = 1'b1;
                exp_q[i].push_back(e);
            end
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            step();
            done = free_m && (cyc >= earliest + 2) && (req_valid == 0);
            for (int i = 0; i < NR; i++) if (src[i].size() > 0) done = 1'b0;
        end
        if (!done) check(1'b0, "drain_timeout", cyc, budget);
    endtask

    int       base, nb, fallc, nstart, nready;
    bit       busy_prev, tkb;
    logic [7:0] db, expb;
    logic [7:0] exp2[5];
    int       exp3[6];

    initial begin
        rst_n = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        req_valid_b = '0; req_data_b = '0; req_last_b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(req_ready == 0,     "rst_req_ready",   req_ready, 0);
        check(tx_data == 0,       "rst_tx_data",     tx_data, 0);
        check(tx_start == 0,      "rst_tx_start",    tx_start, 0);
        check(grant_id == 0,      "rst_grant_id",    grant_id, 0);
        check(locked == 0,        "rst_locked",      locked, 0);
        check(timeout_err == 0,   "rst_timeout_err", timeout_err, 0);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;

        // Single byte
        src[0].push_back({1'b1, 8'h31});
        drain(400);
        check(locked == 0, "single_locked", locked, 0);

        // Locked message while another requester waits
        base = tx_log.size();
        exp2 = '{8'h43, 8'h43, 8'h4E, 8'h55, 8'h50};
        src[1].push_back({1'b0, 8'h43});
        src[1].push_back({1'b0, 8'h43});
        src[1].push_back({1'b0, 8'h4E});
        src[1].push_back({1'b1, 8'h55});
        src[2].push_back({1'b1, 8'h50});
        drain(1000);
        for (int k = 0; k < 5; k++)
            check(base + k < tx_log.size() && tx_log[base + k] == exp2[k], "lock_order",
                  (base + k < tx_log.size()) ? tx_log[base + k] : 8'hxx, exp2[k]);

        // Leave the pointer at 0, then three requesters contend
        src[3].push_back({1'b1, 8'h33});
        drain(400);
        base = grant_log.size();
        exp3 = '{0, 1, 3, 0, 1, 3};
        for (int r = 0; r < 2; r++) begin
            src[0].push_back({1'b1, 8'hA0 + 8'(r)});
            src[1].push_back({1'b1, 8'hB0 + 8'(r)});
            src[3].push_back({1'b1, 8'hD0 + 8'(r)});
        end
        drain(1200);
        for (int k = 0; k < 6; k++)
            check(base + k < grant_log.size() && grant_log[base + k] == exp3[k], "rr_order",
                  (base + k < grant_log.size()) ? grant_log[base + k] : -1, exp3[k]);

        // Busy timeout, then normal service resumes
        tx_dead = 1'b1;
        src[2].push_back({1'b1, 8'h41});
        drain(400);
        check(timeout_err == 1, "timeout_set", timeout_err, 1);
        tx_dead = 1'b0;
        src[0].push_back({1'b1, 8'h42});
        drain(400);
        check(timeout_err == 1, "timeout_sticky", timeout_err, 1);
        check(tx_log.size() > 0 && tx_log[tx_log.size() - 1] == 8'h42, "after_timeout_data",
              (tx_log.size() > 0) ? tx_log[tx_log.size() - 1] : 8'hxx, 8'h42);

        // GAP_CYCLES=0 instance, back-to-back bytes
        db = 8'h60; nb = 0; fallc = -1; busy_prev = 1'b0; expb = '0;
        req_data_b[7:0] = db; req_last_b = 2'b01; req_valid_b = 2'b01;
        for (int t = 0; t < 400 && nb < 4; t++) begin
            @(negedge clk);
            if (busy_prev && !tx_busy_b) fallc = cyc;
            busy_prev = tx_busy_b;
            tkb = req_ready_b[0];
            if (tkb) begin
                if (fallc >= 0) check(cyc - fallc == 2, "gap0_spacing", cyc - fallc, 2);
                expb = req_data_b[7:0];
            end
            if (tx_start_b) begin
                check(tx_data_b == expb, "gap0_data", tx_data_b, expb);
                nb++;
            end
            @(posedge clk);
            #1;
            if (tkb) begin
                db = db + 8'd1;
                req_data_b[7:0] = db;
            end
        end
        req_valid_b = '0;
        check(nb == 4, "gap0_count", nb, 4);

        // Randomised traffic
        rand_mode = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int i, len;
            i   = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                src[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
        end
        drain(20000);
        rand_mode = 1'b0;

        // Reset in the middle of a frame
        src[1].push_back({1'b1, 8'h77});
        for (int t = 0; t < 60 && !tx_busy; t++) step();
        repeat (3) step();
        check(tx_busy == 1, "p6_in_frame", tx_busy, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check(req_ready == 0,   "midrst_req_ready",   req_ready, 0);
        check(tx_data == 0,     "midrst_tx_data",     tx_data, 0);
        check(tx_start == 0,    "midrst_tx_start",    tx_start, 0);
        check(grant_id == 0,    "midrst_grant_id",    grant_id, 0);
        check(locked == 0,      "midrst_locked",      locked, 0);
        check(timeout_err == 0, "midrst_timeout_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        nstart = 0; nready = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_start) nstart++;
            if (req_ready != 0) nready++;
        end
        check(nstart == 0, "post_rst_no_start", nstart, 0);
        check(nready == 0, "post_rst_no_ready", nready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters.
- Arbitration is round-robin with message locking, so a multi-byte message (for example, a four-character reply to a received command) is never interleaved with another requester's bytes.
- The block sequences each byte into the transmitter: load data, strobe start, track busy, then enforce a programmable inter-byte gap.
- It sits between the command/response logic and the transmitter, replacing ad-hoc per-character pulse generation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles after each byte completes before the next launch; 0 skips the gap state.
- BUSY_TIMEOUT, 64, max cycles to wait for tx_busy to rise after tx_start before abandoning the byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte available; must be held, with data stable, until req_ready.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is last of message; sampled with req_data.
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- tx_data  out  8  byte to transmitter; held stable from accept until the next accept.
- tx_start  out  1  1-cycle launch pulse to transmitter.
- tx_busy  in  1  transmitter busy (high while the frame is shifting).
- grant_id  out  clog2(NUM_REQ)  index of current/last owner.
- locked  out  1  high while a message is in progress (last byte not yet accepted).
- timeout_err  out  1  sticky; set on any busy timeout, cleared only by reset.

Behaviour:
- Reset values (async):
  - Outputs: req_ready=0, tx_data=0, tx_start=0, grant_id=0, locked=0, timeout_err=0.
  - Internal: state=IDLE, RR pointer=0, all counters=0.
- States: IDLE, ACCEPT, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, unlocked:
  - If any req_valid, select the first valid index searching from the RR pointer upward with wrap (pointer has highest priority).
  - Register the winner to grant_id and go to ACCEPT.
- IDLE, locked:
  - Only req_valid[grant_id] is considered; other requesters wait indefinitely.
- ACCEPT (1 cycle):
  - req_ready[grant_id]=1.
  - tx_data<=req_data of the owner; last_r<=req_last of the owner.
  - If req_last=0: locked<=1. If req_last=1: locked<=0 and RR pointer<=grant_id+1 (wrap at NUM_REQ).
  - Go to LAUNCH.
- Latency: req_valid first seen in IDLE at cycle n -> req_ready at n+1 -> tx_start at n+2.
- LAUNCH (1 cycle): tx_start=1, clear timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Else increment counter; when counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, set timeout_err<=1 and go to GAP. The byte is dropped, not retried, and lock state is unaffected.
- WAIT_DONE: tx_busy=0 -> GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then IDLE.
- Only one byte is in flight at any time.
- req_ready is never asserted outside ACCEPT; tx_start is never asserted outside LAUNCH.
- A requester asserting valid while another is being served waits; there is no pre-emption.
- tx_busy already high in LAUNCH: WAIT_BUSY exits on its first cycle.
- Owner deasserts req_valid while locked: the block idles, still locked, until the owner resumes.
- Reset mid-operation: any in-flight byte is abandoned. tx_start must not glitch high during or after reset; the first launch after reset requires a fresh request.
- Counter widths are clog2(max+1) of their limit. The comparison must not overflow for parameter maxima up to 2^20.

Test Plan:
- Transmitter model for scenarios 1-4, 6: tx_busy rises 2 cycles after tx_start and stays high 20 cycles. Scenarios 1-5 use GAP_CYCLES=4 and BUSY_TIMEOUT=8.
1. Single byte: req0 sends 0x31 with last=1 at cycle 10 -> req_ready[0] at 11, tx_start at 12, tx_data=0x31; next IDLE 4 cycles after busy falls; RR pointer=1; locked stays 0.
2. Locked message: req1 sends 'C','C','N','U' (0x43,0x43,0x4E,0x55; last on 0x55) while req2 holds 0x50 continuously -> tx_data order 43,43,4E,55,50; locked=1 from first accept until the 0x55 accept.
3. Round-robin: req0, req1, req3 each hold a single-byte last=1 request simultaneously, pointer=0 -> grant order 0,1,3,0,...; no requester is granted twice while another is waiting.
4. Busy timeout: tx_busy tied 0, req2 sends 0x41 -> WAIT_BUSY times out after 8 cycles; timeout_err=1 (stays set); block returns to IDLE and serves the next request.
5. GAP_CYCLES=0 with back-to-back bytes -> next req_ready 1 cycle after tx_busy falls.
6. Reset mid-frame: assert rst_n low during WAIT_DONE -> all outputs are 0 immediately. After release with no req_valid, there is no tx_start and no req_ready for 100 cycles.
